sweep_stim_gen: RTL



---
 rtl/sweep_stim_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sweep_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_stim_gen
//  Description : Exhaustive stimulus generator and MISR response compactor
//                for combinational circuits under test. On start, every one
//                of the 2^N_IN input vectors is driven onto stim and held for
//                HOLD cycles. The response obs is sampled at the final edge of
//                each hold window and folded into a 16-bit MISR (poly 0x1021,
//                seed 0xFFFF).
//  Build macro : SWEEP_GRAY_EN - when defined, vectors are emitted in Gray
//                order (idx ^ idx>>1); otherwise in binary order.
//  Ports       : clk   in   rising-edge clock
//                rst   in   asynchronous active-high reset
//                start in   begin a sweep (accepted only in IDLE)
//                abort in   terminate the sweep (honoured only in DRIVE)
//                obs   in   [N_OUT] response of the circuit under test
//                stim  out  [N_IN]  current stimulus vector (0 when not driving)
//                busy  out  high while vectors are being driven
//                done  out  one-cycle pulse when a sweep completes
//                sig   out  [16]    MISR signature
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_stim_gen #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int HOLD  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] obs,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sig
);

  // Hold counter needs at least one bit even when HOLD == 1.
  localparam int c_hold_w = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD - 1);
  localparam logic [N_IN-1:0]     c_idx_last  = {N_IN{1'b1}};
  localparam logic [15:0]         c_sig_seed  = 16'hFFFF;
  localparam logic [15:0]         c_sig_poly  = 16'h1021;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [N_IN-1:0]       r_idx;
  logic [c_hold_w-1:0]   r_hold;
  logic [15:0]           r_sig;
  logic                  w_window_end;
  logic                  w_sample;
  logic [15:0]           w_sig_next;
  logic [N_IN-1:0]       w_code;

  // Index-to-vector mapping; sweep length and timing are the same in both builds.
`ifdef SWEEP_GRAY_EN
  assign w_code = r_idx ^ (r_idx >> 1);
`else
  assign w_code = r_idx;
`endif

  assign w_window_end = (r_hold == c_hold_last);
  // abort wins over a sample that falls on the same edge
  assign w_sample     = (r_state == S_DRIVE) && !abort && w_window_end;
  assign w_sig_next   = {r_sig[14:0], 1'b0}
                      ^ (r_sig[15] ? c_sig_poly : 16'h0000)
                      ^ 16'(obs);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_window_end && (r_idx == c_idx_last)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Vector index, hold counter and signature
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_hold <= '0;
      r_sig  <= c_sig_seed;
    end else if ((r_state == S_IDLE) && start) begin
      r_idx  <= '0;
      r_hold <= '0;
      r_sig  <= c_sig_seed;
    end else if ((r_state == S_DRIVE) && !abort) begin
      if (w_window_end) begin
        r_hold <= '0;
        // The last index leaves for DONE instead of wrapping.
        if (r_idx != c_idx_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_hold <= r_hold + 1'b1;
      end
      if (w_sample) begin
        r_sig <= w_sig_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from registered state so reset acts on them immediately
  // --------------------------------------------------------------------------
  assign busy = (r_state == S_DRIVE);
  assign done = (r_state == S_DONE);
  assign stim = busy ? w_code : '0;
  assign sig  = r_sig;

endmodule
`default_nettype wire
